sram_bwe_pipe: RTL
==================

SRAM_BWE_PIPE -- requirements
Module: sram_bwe_pipe

Interface
REQ-001 Parameter DATA_W, default 128: word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 1024: number of words; need not be a power of two.
REQ-003 Parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 Parameter RD_LAT, default 1: read latency in cycles, legal range 1..4.
REQ-005 Parameter BYPASS, default 1: 1 = same-cycle read of the address being written returns the new data; 0 = it returns the old data.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 clr_req  input  1  single-cycle request to zero the whole array.
REQ-009 init_done  output  1  high when the array is usable (RUN state).
REQ-010 wr_en, wr_addr[ADDR_W], wr_data[DATA_W], wr_strb[DATA_W/8]  inputs  write request; wr_strb has one bit per byte.
REQ-011 wr_ready  output  1  write port accepts.
REQ-012 rd_en, rd_addr[ADDR_W]  inputs  read request.
REQ-013 rd_ready  output  1  read port accepts.
REQ-014 rd_valid  output  1  rd_data carries a response this cycle.
REQ-015 rd_data  output  DATA_W  read response.

Function
REQ-016 The FSM SHALL have two states: INIT (sweep writes zero to address cnt, one word per cycle, cnt 0..DEPTH-1) and RUN.
REQ-017 INIT->RUN SHALL occur on the edge that writes address DEPTH-1; total INIT duration SHALL be exactly DEPTH cycles.
REQ-018 RUN->INIT SHALL occur on the edge that samples clr_req=1, with cnt reset to 0; clr_req SHALL be ignored in INIT.
REQ-019 init_done, wr_ready and rd_ready SHALL all equal (state==RUN).
REQ-020 A write is accepted when wr_en&wr_ready; for each byte i, the byte SHALL be updated iff wr_strb[i]=1, and all other bytes SHALL retain their previous value.
REQ-021 A write with wr_strb all zero SHALL leave the word unchanged.
REQ-022 A read is accepted when rd_en&rd_ready; the array word SHALL be sampled on the accept edge.
REQ-023 rd_valid SHALL pulse exactly RD_LAT cycles after the accept edge, with the sampled word on rd_data; back-to-back reads SHALL give back-to-back responses, in order, with no bubbles.
REQ-024 A write accepted in the same cycle as a read to the same address SHALL yield the merged new word if BYPASS=1, or the pre-write word if BYPASS=0.
REQ-025 Writes accepted after a read's accept edge SHALL NOT affect that read's response.
REQ-026 Requests presented while not ready SHALL be dropped with no side effect.
REQ-027 Reads already in the latency pipeline when RUN->INIT occurs SHALL still complete with their sampled data.
REQ-028 Addresses >= DEPTH: writes SHALL be ignored; reads SHALL respond normally with all-zero data.
REQ-029 When rd_valid=0, rd_data SHALL hold its last value.

Reset
REQ-030 On rst_n=0, immediately and asynchronously: state=INIT, cnt=0, init_done=0, wr_ready=0, rd_ready=0, rd_valid=0 and all pipeline valids=0, rd_data=0.
REQ-031 Array contents SHALL NOT be reset by rst_n; they SHALL be zeroed by the INIT sweep that follows release.
REQ-032 Reset asserted mid-INIT or mid-read SHALL discard all progress; after release the sweep SHALL restart at address 0.

Verification (DATA_W=128, DEPTH=1024, RD_LAT=2 unless stated)
REQ-033 Release reset -> init_done rises after exactly 1024 clk edges; a read of every address returns 0.
REQ-034 Write addr 5 with all-ones data and strb=16'hFFFF, then write addr 5 with data=0 and strb=16'h0001, then read addr 5 -> 128'hFF..FF00; rd_valid asserts 2 cycles after the read accept.
REQ-035 Same-cycle write and read of addr 9 (data=0xA5 in every byte, full strb), old content 0 -> response is all 0xA5 with BYPASS=1 and 0 with BYPASS=0.
REQ-036 Reads of addrs 1,2,3 on consecutive cycles -> three consecutive rd_valid cycles, with data in order 1,2,3.
REQ-037 Pulse clr_req with one read in flight -> the read completes with its pre-clear data; init_done is low for 1024 cycles; the array afterwards reads 0.
REQ-038 Assert rst_n=0 at INIT cnt=500, then release -> the full 1024-cycle sweep restarts; with DEPTH=1000, a write at addr 1010 is ignored and a read of addr 1010 returns 0.

Source files
------------

// File: rtl/sram_bwe_pipe_if.sv
// Bus bundle for sram_bwe_pipe: clear request/status, byte-enabled write port,
// pipelined read port.
interface sram_bwe_pipe_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 10
);
    logic                  clr_req;
    logic                  init_done;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_strb;
    logic                  wr_ready;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic                  rd_ready;
    logic                  rd_valid;
    logic [DATA_W-1:0]     rd_data;

    modport master (
        output clr_req, wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        input  init_done, wr_ready, rd_ready, rd_valid, rd_data
    );

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
        output init_done, wr_ready, rd_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/sram_bwe_pipe.sv
// Byte-write-enable SRAM model with a zeroing sweep after reset or clear,
// optional same-cycle write-to-read bypass and an RD_LAT-deep read pipeline.
module sram_bwe_pipe #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1,
    parameter int BYPASS = 1
) (
    input logic            clk,
    input logic            rst_n,
    sram_bwe_pipe_if.slave bus
);
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                run;
    logic                wr_acc, wr_hit;
    logic                rd_acc, rd_in_range;
    logic signed [1:0]   unused_sign;
    logic [DATA_W-1:0]   rd_word;
    logic                fin_vld;
    logic [DATA_W-1:0]   fin_data;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rd_data_q;

    // Byte-lane merge: lanes with a set strobe take the new byte, others keep the old one.
    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [NB-1:0]     strb
    );
        logic [DATA_W-1:0] res;
        res = old_w;
        for (int i = 0; i < NB; i++) begin
            if (strb[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    assign unused_sign = 2'sd0;

    // State register and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: sweep one word per cycle in INIT; a clear request restarts the sweep.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT: begin
                if (cnt == LAST_A) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                if (bus.clr_req) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign run           = (state == RUN);
    assign bus.init_done = run;
    assign bus.wr_ready  = run;
    assign bus.rd_ready  = run;

    assign wr_acc      = bus.wr_en & run;
    assign wr_hit      = wr_acc & ({1'b0, bus.wr_addr} < DEPTH_V);
    assign rd_acc      = bus.rd_en & run;
    assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_V);

    // Word seen by a read on its accept edge; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) rd_word = mem[bus.rd_addr];
        if ((BYPASS != 0) && wr_hit && (bus.wr_addr == bus.rd_addr))
            rd_word = merge_bytes(rd_word, bus.wr_data, bus.wr_strb);
    end

    // Array update: zero sweep in INIT, byte-merged writes in RUN. Contents are never reset.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[cnt] <= '0;
        end else if (wr_hit) begin
            mem[bus.wr_addr] <= merge_bytes(mem[bus.wr_addr], bus.wr_data, bus.wr_strb);
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign fin_vld  = rd_acc;
            assign fin_data = rd_word;
        end else begin : g_latn
            logic                vld_p  [RD_LAT-1];
            logic [DATA_W-1:0]   data_p [RD_LAT-1];

            // Stage p0..pN valid shift; runs independently of the FSM so in-flight reads finish.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < RD_LAT - 1; i++) vld_p[i] <= 1'b0;
                end else begin
                    vld_p[0] <= rd_acc;
                    for (int i = 1; i < RD_LAT - 1; i++) vld_p[i] <= vld_p[i-1];
                end
            end

            // Stage p0..pN data, advanced only alongside a valid.
            always_ff @(posedge clk) begin
                if (rd_acc) data_p[0] <= rd_word;
                for (int i = 1; i < RD_LAT - 1; i++) begin
                    if (vld_p[i-1]) data_p[i] <= data_p[i-1];
                end
            end

            assign fin_vld  = vld_p[RD_LAT-2];
            assign fin_data = data_p[RD_LAT-2];
        end
    endgenerate

    // Output stage: rd_data is loaded only with a response and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= fin_vld;
            if (fin_vld) rd_data_q <= fin_data;
        end
    end

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule
